// File: rtl/gradients_pipe.sv
// Three-stage 5x5 Bayer-patch gradient engine with valid/ready handshake.
// Produces saturated H/V/full/weighted gradients and an interpolation direction.
module gradients_pipe #(
    parameter int PIX_W = 12,
    parameter int OUT_W = 8,
    parameter int SHIFT = 2,
    parameter int THR   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [25*PIX_W-1:0]  patch,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     grad_h,
    output logic [OUT_W-1:0]     grad_v,
    output logic [OUT_W-1:0]     grad_hf,
    output logic [OUT_W-1:0]     grad_vf,
    output logic [OUT_W-1:0]     w_grad_h,
    output logic [OUT_W-1:0]     w_grad_v,
    output logic [1:0]           dir,
    output logic [15:0]          out_count
);

    localparam int SW = PIX_W + 2;
    localparam int WW = PIX_W + 3;
    localparam int CW = PIX_W + 4;
    localparam logic [WW-1:0] SAT_MAX = WW'((1 << OUT_W) - 1);

    function automatic logic [PIX_W-1:0] abs_px(input logic [PIX_W-1:0] x, input logic [PIX_W-1:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [PIX_W:0] abs_wide(input logic [PIX_W:0] x, input logic [PIX_W:0] y);
        return (x > y) ? (x - y) : (y - x);
    endfunction

    function automatic logic [OUT_W-1:0] sat(input logic [WW-1:0] raw);
        logic [WW-1:0] s;
        s = raw >> SHIFT;
        return (s > SAT_MAX) ? SAT_MAX[OUT_W-1:0] : s[OUT_W-1:0];
    endfunction

    logic en;
    logic accept;

    // One global enable: the whole pipe advances only when the output slot frees up.
    assign en       = !out_valid || out_ready;
    assign in_ready = !rst && en;
    assign accept   = in_valid && in_ready;

    // p[(r+2)*5+(c+2)] is pixel P(r,c)
    logic [PIX_W-1:0] p [25];

    genvar gi;
    generate
        for (gi = 0; gi < 25; gi++) begin : g_unpack
            assign p[gi] = patch[gi*PIX_W +: PIX_W];
        end
    endgenerate

    // ---------------- stage 1: absolute differences ----------------
    logic [PIX_W-1:0] a_h_next, a_v_next;
    logic [PIX_W:0]   b_h_next, b_v_next;
    logic [PIX_W-1:0] d_h_next [3];
    logic [PIX_W-1:0] d_v_next [3];

    logic             v1_reg;
    logic [PIX_W-1:0] a_h_reg, a_v_reg;
    logic [PIX_W:0]   b_h_reg, b_v_reg;
    logic [PIX_W-1:0] d_h_reg [3];
    logic [PIX_W-1:0] d_v_reg [3];

    always_comb begin
        a_h_next = abs_px(p[11], p[13]);
        a_v_next = abs_px(p[7], p[17]);
        b_h_next = abs_wide({p[12], 1'b0}, {1'b0, p[10]} + {1'b0, p[14]});
        b_v_next = abs_wide({p[12], 1'b0}, {1'b0, p[2]} + {1'b0, p[22]});
    end

    generate
        for (gi = 0; gi < 3; gi++) begin : g_diff
            // row/column offset gi-1 around the centre
            assign d_h_next[gi] = abs_px(p[(gi+1)*5 + 1], p[(gi+1)*5 + 3]);
            assign d_v_next[gi] = abs_px(p[5 + gi + 1], p[15 + gi + 1]);

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    d_h_reg[gi] <= '0;
                    d_v_reg[gi] <= '0;
                end else if (en) begin
                    d_h_reg[gi] <= d_h_next[gi];
                    d_v_reg[gi] <= d_v_next[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_reg  <= 1'b0;
            a_h_reg <= '0;
            a_v_reg <= '0;
            b_h_reg <= '0;
            b_v_reg <= '0;
        end else if (en) begin
            v1_reg  <= accept;
            a_h_reg <= a_h_next;
            a_v_reg <= a_v_next;
            b_h_reg <= b_h_next;
            b_v_reg <= b_v_next;
        end
    end

    // ---------------- stage 2: raw sums ----------------
    logic [SW-1:0] hr_next, vr_next, hf_next, vf_next;
    logic [WW-1:0] wh_next, wv_next;

    logic          v2_reg;
    logic [SW-1:0] hr_reg, vr_reg, hf_reg, vf_reg;
    logic [WW-1:0] wh_reg, wv_reg;

    always_comb begin
        hr_next = SW'(a_h_reg) + SW'(b_h_reg);
        vr_next = SW'(a_v_reg) + SW'(b_v_reg);
        hf_next = SW'(d_h_reg[0]) + SW'(d_h_reg[1]) + SW'(d_h_reg[2]);
        vf_next = SW'(d_v_reg[0]) + SW'(d_v_reg[1]) + SW'(d_v_reg[2]);
        wh_next = WW'(hr_next) + WW'(hf_next >> 1);
        wv_next = WW'(vr_next) + WW'(vf_next >> 1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2_reg <= 1'b0;
            hr_reg <= '0;
            vr_reg <= '0;
            hf_reg <= '0;
            vf_reg <= '0;
            wh_reg <= '0;
            wv_reg <= '0;
        end else if (en) begin
            v2_reg <= v1_reg;
            hr_reg <= hr_next;
            vr_reg <= vr_next;
            hf_reg <= hf_next;
            vf_reg <= vf_next;
            wh_reg <= wh_next;
            wv_reg <= wv_next;
        end
    end

    // ---------------- stage 3: saturation and direction ----------------
    logic [CW-1:0] wh_c, wv_c, thr_c;
    logic [1:0]    dir_next;

    // Direction uses the full-precision weighted sums, widened so +THR cannot wrap.
    always_comb begin
        wh_c  = CW'(wh_reg);
        wv_c  = CW'(wv_reg);
        thr_c = CW'(THR);
        if (wh_c + thr_c < wv_c)
            dir_next = 2'b01;
        else if (wv_c + thr_c < wh_c)
            dir_next = 2'b10;
        else
            dir_next = 2'b00;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            grad_h    <= '0;
            grad_v    <= '0;
            grad_hf   <= '0;
            grad_vf   <= '0;
            w_grad_h  <= '0;
            w_grad_v  <= '0;
            dir       <= 2'b00;
        end else if (en) begin
            out_valid <= v2_reg;
            grad_h    <= sat(WW'(hr_reg));
            grad_v    <= sat(WW'(vr_reg));
            grad_hf   <= sat(WW'(hf_reg));
            grad_vf   <= sat(WW'(vf_reg));
            w_grad_h  <= sat(wh_reg);
            w_grad_v  <= sat(wv_reg);
            dir       <= dir_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            out_count <= 16'd0;
        else if (out_valid && out_ready)
            out_count <= out_count + 16'd1;
    end

endmodule

// File: tb/tb_gradients_pipe.sv
// Randomised and directed bench for gradients_pipe; a plain-integer model of the
// gradient formulas feeds an in-order scoreboard.
module tb_gradients_pipe;

    localparam int PIX_W = 12;
    localparam int OUT_W = 8;
    localparam int SHIFT = 2;
    localparam int THR   = 16;
    localparam int PW    = 25 * PIX_W;
    localparam int OMAX  = (1 << OUT_W) - 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PW-1:0]    patch;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] grad_h, grad_v, grad_hf, grad_vf, w_grad_h, w_grad_v;
    logic [1:0]       dir;
    logic [15:0]      out_count;

    gradients_pipe #(.PIX_W(PIX_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .THR(THR)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .patch(patch),
        .out_valid(out_valid), .out_ready(out_ready),
        .grad_h(grad_h), .grad_v(grad_v), .grad_hf(grad_hf), .grad_vf(grad_vf),
        .w_grad_h(w_grad_h), .w_grad_v(w_grad_v), .dir(dir), .out_count(out_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int gh, gv, ghf, gvf, wgh, wgv, dir;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            n_out = 0;
    int            n_acc = 0;
    int            exp_count = 0;
    bit            hold_prev = 1'b0;
    logic [49:0]   held;
    logic [PW-1:0] bp [6];
    int            lat, idx, base, guard;
    bit            acc;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int px(input logic [PW-1:0] v, input int r, input int c);
        return int'(v[((r+2)*5 + (c+2))*PIX_W +: PIX_W]);
    endfunction

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int satv(input int raw);
        int s;
        s = raw / (1 << SHIFT);
        return (s > OMAX) ? OMAX : s;
    endfunction

    function automatic exp_t model(input logic [PW-1:0] v);
        exp_t m;
        int hr, vr, hf, vf, wh, wv;
        hr = iabs(px(v,0,-1) - px(v,0,1)) + iabs(2*px(v,0,0) - px(v,0,-2) - px(v,0,2));
        vr = iabs(px(v,-1,0) - px(v,1,0)) + iabs(2*px(v,0,0) - px(v,-2,0) - px(v,2,0));
        hf = 0;
        vf = 0;
        for (int k = -1; k <= 1; k++) begin
            hf += iabs(px(v,k,-1) - px(v,k,1));
            vf += iabs(px(v,-1,k) - px(v,1,k));
        end
        wh = hr + hf / 2;
        wv = vr + vf / 2;
        m.gh  = satv(hr);
        m.gv  = satv(vr);
        m.ghf = satv(hf);
        m.gvf = satv(vf);
        m.wgh = satv(wh);
        m.wgv = satv(wv);
        m.dir = (wh + THR < wv) ? 1 : ((wv + THR < wh) ? 2 : 0);
        return m;
    endfunction

    // kind: 0 flat, 1 horizontal ramp, 2 vertical ramp, 3 single hot pixel, 4 noise, 5 noisy slopes
    function automatic logic [PW-1:0] gen(input int kind);
        logic [PW-1:0] v;
        int val, sh, sv;
        v  = '0;
        sh = int'($urandom_range(0, 300));
        sv = int'($urandom_range(0, 300));
        for (int r = -2; r <= 2; r++) begin
            for (int c = -2; c <= 2; c++) begin
                case (kind)
                    0:       val = 1000;
                    1:       val = 1000 + 100*c;
                    2:       val = 1000 + 100*r;
                    3:       val = (r == 0 && c == -1) ? 4095 : 0;
                    4:       val = int'($urandom_range(0, 4095));
                    default: val = 2000 + sh*c + sv*r + int'($urandom_range(0, 40));
                endcase
                v[((r+2)*5 + (c+2))*PIX_W +: PIX_W] = PIX_W'(val);
            end
        end
        return v;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(posedge clk);
        #2;
        rst = 1'b1;
        exp_q.delete();
        exp_count = 0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    // Sends one patch with out_ready high and stops at the negedge where out_valid is first seen.
    task automatic run_one(input int kind, output int latency);
        int n;
        out_ready = 1'b1;
        patch     = gen(kind);
        in_valid  = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 20) begin
            tick();
            @(negedge clk);
            n++;
        end
        if (n >= 20) check("accept_timeout", 0, 1);
        tick();
        in_valid = 1'b0;
        latency  = 0;
        do begin
            @(negedge clk);
            latency++;
        end while (!out_valid && latency < 20);
        if (latency >= 20) check("result_timeout", 0, 1);
    endtask

    // Scoreboard / protocol monitor, sampling on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            check("in_ready", in_ready, !rst && (!out_valid || out_ready));
            if (rst) begin
                hold_prev = 1'b0;
                continue;
            end
            check("out_count", out_count, exp_count % 65536);
            if (hold_prev) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {grad_h, grad_v, grad_hf, grad_vf, w_grad_h, w_grad_v, dir}, held);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("grad_h", grad_h, e.gh);
                    check("grad_v", grad_v, e.gv);
                    check("grad_hf", grad_hf, e.ghf);
                    check("grad_vf", grad_vf, e.gvf);
                    check("w_grad_h", w_grad_h, e.wgh);
                    check("w_grad_v", w_grad_v, e.wgv);
                    check("dir", dir, e.dir);
                end
                n_out++;
                exp_count++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(patch));
                n_acc++;
            end
            hold_prev = out_valid && !out_ready;
            held = {grad_h, grad_v, grad_hf, grad_vf, w_grad_h, w_grad_v, dir};
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        patch     = '0;
        repeat (2) tick();
        check("rst_out_valid", out_valid, 0);
        check("rst_out_count", out_count, 0);
        check("rst_grad_h", grad_h, 0);
        check("rst_dir", dir, 0);
        check("rst_in_ready", in_ready, 0);
        rst = 1'b0;
        tick();

        // flat patch
        run_one(0, lat);
        check("flat_latency", lat, 3);
        check("flat_grad_h", grad_h, 0);
        check("flat_grad_v", grad_v, 0);
        check("flat_grad_hf", grad_hf, 0);
        check("flat_w_grad_h", w_grad_h, 0);
        check("flat_dir", dir, 0);
        tick();
        check("flat_count", out_count, 1);

        // horizontal ramp
        run_one(1, lat);
        check("hramp_grad_h", grad_h, 50);
        check("hramp_grad_v", grad_v, 0);
        check("hramp_grad_hf", grad_hf, 150);
        check("hramp_grad_vf", grad_vf, 0);
        check("hramp_w_grad_h", w_grad_h, 125);
        check("hramp_w_grad_v", w_grad_v, 0);
        check("hramp_dir", dir, 2);
        tick();

        // vertical ramp
        run_one(2, lat);
        check("vramp_grad_h", grad_h, 0);
        check("vramp_grad_v", grad_v, 50);
        check("vramp_grad_vf", grad_vf, 150);
        check("vramp_w_grad_v", w_grad_v, 125);
        check("vramp_dir", dir, 1);
        tick();

        // saturation
        run_one(3, lat);
        check("sat_grad_h", grad_h, 255);
        check("sat_grad_hf", grad_hf, 255);
        check("sat_w_grad_h", w_grad_h, 255);
        check("sat_grad_v", grad_v, 0);
        check("sat_dir", dir, 2);
        tick();

        // backpressure: 6 offered with out_ready low, only 3 fit
        do_reset();
        tick();
        base = n_out;
        for (int i = 0; i < 6; i++) bp[i] = gen(4);
        out_ready = 1'b0;
        idx       = 0;
        patch     = bp[0];
        in_valid  = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            check("bp_ready", in_ready, !out_valid);
            acc = in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 6) patch = bp[idx];
            end
        end
        check("bp_accepted", idx, 3);
        out_ready = 1'b1;
        guard = 0;
        while (idx < 6 && guard < 30) begin
            @(negedge clk);
            acc = in_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx < 6) patch = bp[idx];
            end
            guard++;
        end
        in_valid = 1'b0;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        check("bp_drain_timeout", guard < 20, 1);
        check("bp_results", n_out - base, 6);
        check("bp_count", out_count, 6);

        // asynchronous reset with three patches in flight
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            patch = gen(4);
            tick();
        end
        in_valid = 1'b0;
        #3;
        rst = 1'b1;
        exp_q.delete();
        exp_count = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_out_count", out_count, 0);
        check("arst_grad_h", grad_h, 0);
        check("arst_grad_hf", grad_hf, 0);
        check("arst_w_grad_v", w_grad_v, 0);
        check("arst_dir", dir, 0);
        check("arst_in_ready", in_ready, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("arst_no_out", out_valid, 0);
        end
        tick();

        // random traffic
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            patch     = gen(int'($urandom_range(4, 5)));
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
            tick();
            guard++;
        end
        check("rand_drain", exp_q.size(), 0);

        // full-rate stream across the counter wrap
        do_reset();
        tick();
        base      = n_out;
        out_ready = 1'b1;
        patch     = gen(0);
        in_valid  = 1'b1;
        repeat (65537) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("wrap_results", n_out - base, 65537);
        check("wrap_count", out_count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
